wb_arbiter: RTL and testbench

Writeback arbiter that drives the integer register file's single write port. It accepts completed results from the execute path (EXU) and the load/store path (LSU) over valid/ready handshakes, and arbitrates between them with LSU priority and a starvation guard. The winning result is held in a one-entry output stage and written to the register file on the following edge. It sits between EXU/LSU and the IDU register file; an optional forwarding port serves IDU reads that collide with the pending write.

---
 rtl/wb_arbiter_if.sv | 58 +++++
 rtl/wb_arbiter.sv | 97 +++++++++
 tb/tb_wb_arbiter.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_if.sv
//------------------------------------------------------------------------------
// wb_arbiter_if : EXU/LSU result handshakes, register-file write port, forwarding
// Rev 1.0 : initial release. Optional macro: WB_FWD_EN (forwarding signals)
//------------------------------------------------------------------------------
`default_nettype none

interface wb_arbiter_if;
  logic        flush;
  logic        exu_valid;
  logic        exu_ready;
  logic [4:0]  exu_rd;
  logic        exu_wen;
  logic [63:0] exu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic        lsu_wen;
  logic [63:0] lsu_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic        commit;
  logic        commit_src;
`ifdef WB_FWD_EN
  logic [4:0]  fwd_raddr1;
  logic [4:0]  fwd_raddr2;
  logic        fwd_hit1;
  logic        fwd_hit2;
  logic [63:0] fwd_data1;
  logic [63:0] fwd_data2;
`endif

  modport slave (
`ifdef WB_FWD_EN
    input  fwd_raddr1, fwd_raddr2,
    output fwd_hit1, fwd_hit2, fwd_data1, fwd_data2,
`endif
    input  flush,
    input  exu_valid, exu_rd, exu_wen, exu_data,
    input  lsu_valid, lsu_rd, lsu_wen, lsu_data,
    output exu_ready, lsu_ready,
    output rf_we, rf_waddr, rf_wdata, commit, commit_src
  );

  modport master (
`ifdef WB_FWD_EN
    output fwd_raddr1, fwd_raddr2,
    input  fwd_hit1, fwd_hit2, fwd_data1, fwd_data2,
`endif
    output flush,
    output exu_valid, exu_rd, exu_wen, exu_data,
    output lsu_valid, lsu_rd, lsu_wen, lsu_data,
    input  exu_ready, lsu_ready,
    input  rf_we, rf_waddr, rf_wdata, commit, commit_src
  );
endinterface

`default_nettype wire

// File: rtl/wb_arbiter.sv
//------------------------------------------------------------------------------
// wb_arbiter : LSU-priority writeback arbiter with EXU starvation guard and a
//              one-entry output stage driving the register-file write port.
// Rev 1.0 : initial release. Optional macro: WB_FWD_EN (read forwarding)
//------------------------------------------------------------------------------
`default_nettype none

module wb_arbiter #(
  parameter int unsigned STARVE_MAX = 3
) (
  input  wire logic    clk,
  input  wire logic    rst,
  wb_arbiter_if.slave  bus
);

  localparam logic [3:0] c_STARVE_MAX = 4'(STARVE_MAX);

  logic [3:0]  r_starve_cnt;
  logic        r_st_valid;
  logic        r_st_wen;
  logic [4:0]  r_st_rd;
  logic [63:0] r_st_data;
  logic        r_st_src;

  logic        w_starved;
  logic        w_gnt_exu;
  logic        w_gnt_lsu;
  logic        w_rf_we;

  always_comb begin
    w_starved = (r_starve_cnt == c_STARVE_MAX);
    w_gnt_exu = !bus.flush && bus.exu_valid && (!bus.lsu_valid || w_starved);
    w_gnt_lsu = !bus.flush && bus.lsu_valid && !w_gnt_exu;
  end

  assign bus.exu_ready = w_gnt_exu;
  assign bus.lsu_ready = w_gnt_lsu;

  // Counts EXU losses only; flush freezes it so a flush cannot reset fairness.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve_cnt <= 4'd0;
    end else if (!bus.flush) begin
      if (!bus.exu_valid || w_gnt_exu) begin
        r_starve_cnt <= 4'd0;
      end else if (r_starve_cnt != c_STARVE_MAX) begin
        r_starve_cnt <= r_starve_cnt + 4'd1;
      end
    end
  end

  // Stage drains every cycle; grants are already suppressed during flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st_valid <= 1'b0;
      r_st_wen   <= 1'b0;
      r_st_rd    <= 5'd0;
      r_st_data  <= 64'd0;
      r_st_src   <= 1'b0;
    end else begin
      r_st_valid <= w_gnt_exu || w_gnt_lsu;
      if (w_gnt_lsu) begin
        r_st_wen  <= bus.lsu_wen;
        r_st_rd   <= bus.lsu_rd;
        r_st_data <= bus.lsu_data;
        r_st_src  <= 1'b1;
      end else if (w_gnt_exu) begin
        r_st_wen  <= bus.exu_wen;
        r_st_rd   <= bus.exu_rd;
        r_st_data <= bus.exu_data;
        r_st_src  <= 1'b0;
      end
    end
  end

  assign w_rf_we        = r_st_valid && r_st_wen && (r_st_rd != 5'd0);
  assign bus.rf_we      = w_rf_we;
  assign bus.rf_waddr   = r_st_rd;
  assign bus.rf_wdata   = r_st_data;
  assign bus.commit     = r_st_valid;
  assign bus.commit_src = r_st_src;

`ifdef WB_FWD_EN
  logic w_fwd_hit1;
  logic w_fwd_hit2;

  assign w_fwd_hit1    = w_rf_we && (r_st_rd == bus.fwd_raddr1);
  assign w_fwd_hit2    = w_rf_we && (r_st_rd == bus.fwd_raddr2);
  assign bus.fwd_hit1  = w_fwd_hit1;
  assign bus.fwd_hit2  = w_fwd_hit2;
  assign bus.fwd_data1 = w_fwd_hit1 ? r_st_data : 64'd0;
  assign bus.fwd_data2 = w_fwd_hit2 ? r_st_data : 64'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter.sv
//------------------------------------------------------------------------------
// tb_wb_arbiter : directed scoreboard bench for wb_arbiter (STARVE_MAX = 3)
// Rev 1.0 : initial release. Optional macro: WB_FWD_EN (forwarding checks)
//------------------------------------------------------------------------------
`default_nettype none

module tb_wb_arbiter;

  localparam int unsigned c_STARVE_MAX = 3;

  typedef struct packed {
    logic        src;
    logic        we;
    logic [4:0]  addr;
    logic [63:0] data;
  } wb_exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   m_starve;
  int   win;
  wb_exp_t sb[$];

  wb_arbiter_if bus ();

  wb_arbiter #(.STARVE_MAX(c_STARVE_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_exu(input logic v, input logic [4:0] rd, input logic wen, input logic [63:0] d);
    bus.exu_valid = v; bus.exu_rd = rd; bus.exu_wen = wen; bus.exu_data = d;
  endtask

  task automatic set_lsu(input logic v, input logic [4:0] rd, input logic wen, input logic [63:0] d);
    bus.lsu_valid = v; bus.lsu_rd = rd; bus.lsu_wen = wen; bus.lsu_data = d;
  endtask

  // One cycle: check grant, push expected retire, clock, then check the stage.
  task automatic step(input string tag);
    logic    e_gnt, l_gnt;
    wb_exp_t e;
    #1;
    e_gnt = !bus.flush && bus.exu_valid && (!bus.lsu_valid || m_starve == c_STARVE_MAX);
    l_gnt = !bus.flush && bus.lsu_valid && !e_gnt;
    chk({tag, "_exu_ready"}, 64'(bus.exu_ready), 64'(e_gnt));
    chk({tag, "_lsu_ready"}, 64'(bus.lsu_ready), 64'(l_gnt));
    win = bus.exu_ready ? 1 : (bus.lsu_ready ? 2 : 0);
    if (l_gnt) begin
      e = '{src: 1'b1, we: bus.lsu_wen && (bus.lsu_rd != 5'd0), addr: bus.lsu_rd, data: bus.lsu_data};
      sb.push_back(e);
    end else if (e_gnt) begin
      e = '{src: 1'b0, we: bus.exu_wen && (bus.exu_rd != 5'd0), addr: bus.exu_rd, data: bus.exu_data};
      sb.push_back(e);
    end
    if (!bus.flush) begin
      if (!bus.exu_valid || e_gnt) m_starve = 0;
      else if (m_starve < c_STARVE_MAX) m_starve++;
    end
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_commit"}, 64'(bus.commit), 64'd1);
      chk({tag, "_src"}, 64'(bus.commit_src), 64'(e.src));
      chk({tag, "_rf_we"}, 64'(bus.rf_we), 64'(e.we));
      chk({tag, "_waddr"}, 64'(bus.rf_waddr), 64'(e.addr));
      chk({tag, "_wdata"}, bus.rf_wdata, e.data);
    end else begin
      chk({tag, "_idle_commit"}, 64'(bus.commit), 64'd0);
      chk({tag, "_idle_rf_we"}, 64'(bus.rf_we), 64'd0);
    end
  endtask

  initial begin
    int exp_win[8];
    checks = 0; failures = 0; m_starve = 0; win = 0;
    exp_win = '{2, 2, 2, 1, 2, 2, 2, 1};
    bus.flush = 1'b0;
`ifdef WB_FWD_EN
    bus.fwd_raddr1 = 5'd0;
    bus.fwd_raddr2 = 5'd0;
`endif
    rst = 1'b1;
    set_exu(1'b1, 5'd1, 1'b1, 64'h11);
    set_lsu(1'b1, 5'd2, 1'b1, 64'h22);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rf_we", 64'(bus.rf_we), 64'd0);
    chk("rst_commit", 64'(bus.commit), 64'd0);
    chk("rst_wdata", bus.rf_wdata, 64'd0);
    chk("rst_waddr", 64'(bus.rf_waddr), 64'd0);
    chk("rst_lsu_ready", 64'(bus.lsu_ready), 64'd1);
    chk("rst_exu_ready", 64'(bus.exu_ready), 64'd0);
    set_exu(1'b0, 5'd0, 1'b0, 64'd0);
    set_lsu(1'b0, 5'd0, 1'b0, 64'd0);
    rst = 1'b0;
    step("post_rst_idle");

    set_exu(1'b1, 5'd5, 1'b1, 64'h1234);
    step("exu_only");
    set_exu(1'b0, 5'd0, 1'b0, 64'd0);
    step("idle1");

    for (int i = 0; i < 8; i++) begin
      set_exu(1'b1, 5'(10 + i), 1'b1, 64'h1000 + 64'(i));
      set_lsu(1'b1, 5'(20 + i), 1'b1, 64'h2000 + 64'(i));
      step("both");
      chk("order", 64'(win), 64'(exp_win[i]));
    end
    set_exu(1'b0, 5'd0, 1'b0, 64'd0);

    set_lsu(1'b1, 5'd0, 1'b1, 64'hFF);
    step("lsu_x0");
    set_lsu(1'b1, 5'd7, 1'b0, 64'hFF);
    step("lsu_nowen");
    set_lsu(1'b0, 5'd0, 1'b0, 64'd0);
    step("idle2");

    set_exu(1'b1, 5'd6, 1'b1, 64'h66);
    set_lsu(1'b1, 5'd4, 1'b1, 64'h44);
    step("pre_flush_a");
    set_lsu(1'b1, 5'd3, 1'b1, 64'h33);
    step("pre_flush_b");
    bus.flush = 1'b1;
    #1;
    chk("flush_rf_we_kept", 64'(bus.rf_we), 64'd1);
    chk("flush_waddr_kept", 64'(bus.rf_waddr), 64'd3);
    step("flush");
    bus.flush = 1'b0;
    set_lsu(1'b1, 5'd8, 1'b1, 64'h88);
    step("post_flush_a");
    chk("post_flush_order_a", 64'(win), 64'd2);
    step("post_flush_b");
    chk("post_flush_order_b", 64'(win), 64'd1);
    set_exu(1'b0, 5'd0, 1'b0, 64'd0);
    set_lsu(1'b0, 5'd0, 1'b0, 64'd0);
    step("idle3");

    set_exu(1'b1, 5'd4, 1'b1, 64'h44);
    step("pre_rst");
    set_exu(1'b0, 5'd0, 1'b0, 64'd0);
    rst = 1'b1;
    #1;
    chk("midrst_commit", 64'(bus.commit), 64'd0);
    chk("midrst_rf_we", 64'(bus.rf_we), 64'd0);
    chk("midrst_wdata", bus.rf_wdata, 64'd0);
    sb.delete();
    m_starve = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    step("post_midrst");

`ifdef WB_FWD_EN
    set_exu(1'b1, 5'd9, 1'b1, 64'hABCD);
    step("fwd_fill");
    set_exu(1'b0, 5'd0, 1'b0, 64'd0);
    bus.fwd_raddr1 = 5'd9;
    bus.fwd_raddr2 = 5'd0;
    #1;
    chk("fwd_hit1", 64'(bus.fwd_hit1), 64'd1);
    chk("fwd_data1", bus.fwd_data1, 64'hABCD);
    chk("fwd_hit2", 64'(bus.fwd_hit2), 64'd0);
    chk("fwd_data2", bus.fwd_data2, 64'd0);
    step("fwd_drain");
`endif

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
